// File: rtl/fc_mac_array.sv
// rtl/fc_mac_array.sv - LANES-wide broadcast MAC with length-programmed vectors; FC_MAC_SAT_EN enables saturating accumulators
module fc_mac_array #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_run,
   input  logic [LEN_W-1:0]         i_len,
   input  logic                     i_signed,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [DATA_W-1:0]        i_node,
   input  logic [LANES*DATA_W-1:0]  i_wegt,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [LANES*ACC_W-1:0]   o_result,
   output logic                     o_busy,
   output logic [LANES-1:0]         o_sat
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t                          state_q, state_d;
   logic [LEN_W-1:0]                len_q, len_d;
   logic [LEN_W-1:0]                cnt_q, cnt_d;
   logic                            signed_q, signed_d;
   logic                            ready_q, ready_d;
   logic                            valid_q, valid_d;
   logic                            pvld_q, pvld_d;
   logic [LANES-1:0][PROD_W-1:0]    prod_q, prod_d;
   logic [LANES-1:0][ACC_W-1:0]     acc_q, acc_d;
   logic [LANES-1:0]                sat_q, sat_d;

   logic                            accept;
   logic [LEN_W-1:0]                cnt_inc;
   logic [PROD_W-1:0]               node_x;
   logic [LANES-1:0][PROD_W-1:0]    wegt_x;
   logic [LANES-1:0][PROD_W-1:0]    prod_now;
   logic [LANES-1:0][ACC_W-1:0]     addend;
   logic [LANES-1:0][ACC_W-1:0]     acc_sum;
   logic [LANES-1:0][ACC_W-1:0]     acc_fin;
   logic [LANES-1:0]                clamp;

   assign accept  = i_valid && ready_q;
   assign cnt_inc = cnt_q + LEN_W'(1);

   // Stage 1 operands: extending both to the full product width makes the low product bits correct in either mode
   always_comb begin
      node_x = signed_q ? PROD_W'($signed(i_node)) : PROD_W'(i_node);
      for (int k = 0; k < LANES; k++) begin
         wegt_x[k]   = signed_q ? PROD_W'($signed(i_wegt[k*DATA_W +: DATA_W]))
                                : PROD_W'(i_wegt[k*DATA_W +: DATA_W]);
         prod_now[k] = node_x * wegt_x[k];
      end
   end

   // Stage 2 add, with optional clamp to the mode's accumulator range
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         addend[k]  = signed_q ? ACC_W'($signed(prod_q[k])) : ACC_W'(prod_q[k]);
         acc_sum[k] = acc_q[k] + addend[k];
         acc_fin[k] = acc_sum[k];
         clamp[k]   = 1'b0;
`ifdef FC_MAC_SAT_EN
         if (signed_q) begin
            if ((acc_q[k][ACC_W-1] == addend[k][ACC_W-1]) &&
                (acc_sum[k][ACC_W-1] != acc_q[k][ACC_W-1])) begin
               clamp[k]   = 1'b1;
               acc_fin[k] = acc_q[k][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
            end
         end else if (acc_sum[k] < acc_q[k]) begin
            clamp[k]   = 1'b1;
            acc_fin[k] = '1;
         end
`endif
      end
   end

   // Control FSM and pipeline next-state; i_run overrides everything except an i_len=0 run from IDLE
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      signed_d = signed_q;
      ready_d  = ready_q;
      valid_d  = valid_q;
      pvld_d   = accept;
      prod_d   = accept ? prod_now : prod_q;
      acc_d    = acc_q;
      sat_d    = sat_q;

      if (pvld_q) begin
         acc_d = acc_fin;
         sat_d = sat_q | clamp;
      end

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b0;
            valid_d = 1'b0;
         end
         ST_RUN: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = ST_DRAIN;
                  ready_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
            valid_d = 1'b1;
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            valid_d = 1'b0;
         end
      endcase

      if (i_run && ((state_q != ST_IDLE) || (i_len != '0))) begin
         len_d    = i_len;
         signed_d = i_signed;
         cnt_d    = '0;
         pvld_d   = 1'b0;
         acc_d    = '0;
         sat_d    = '0;
         valid_d  = 1'b0;
         if (i_len != '0) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end else begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         signed_q <= 1'b0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         pvld_q   <= 1'b0;
         prod_q   <= '0;
         acc_q    <= '0;
         sat_q    <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         signed_q <= signed_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         pvld_q   <= pvld_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         sat_q    <= sat_d;
      end
   end

   assign o_ready  = ready_q;
   assign o_valid  = valid_q;
   assign o_busy   = (state_q != ST_IDLE);
   assign o_result = acc_q;
   assign o_sat    = sat_q;

endmodule

// File: tb/tb_fc_mac_array.sv
// tb/tb_fc_mac_array.sv - directed self-checking bench for fc_mac_array
module tb_fc_mac_array;

   logic          clk;
   logic          reset_n;
   logic          i_run;
   logic [15:0]   i_len;
   logic          i_signed;
   logic          i_valid;
   logic [7:0]    i_node;
   logic [31:0]   i_wegt;
   logic          i_ready;

   logic          o_ready, o_valid, o_busy;
   logic [127:0]  o_result;
   logic [3:0]    o_sat;

   logic          o_ready16, o_valid16, o_busy16;
   logic [63:0]   o_result16;
   logic [3:0]    o_sat16;

   int checks;
   int errors;

   fc_mac_array dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_run    (i_run),
      .i_len    (i_len),
      .i_signed (i_signed),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_node   (i_node),
      .i_wegt   (i_wegt),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_busy   (o_busy),
      .o_sat    (o_sat)
   );

   fc_mac_array #(.ACC_W(16)) dut16 (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_run    (i_run),
      .i_len    (i_len),
      .i_signed (i_signed),
      .i_valid  (i_valid),
      .o_ready  (o_ready16),
      .i_node   (i_node),
      .i_wegt   (i_wegt),
      .o_valid  (o_valid16),
      .i_ready  (i_ready),
      .o_result (o_result16),
      .o_busy   (o_busy16),
      .o_sat    (o_sat16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [15:0] len, input logic sgn);
      @(negedge clk);
      i_run    = 1'b1;
      i_len    = len;
      i_signed = sgn;
      @(negedge clk);
      i_run    = 1'b0;
   endtask

   task automatic beat(input logic [7:0] node, input logic [31:0] wegt);
      i_valid = 1'b1;
      i_node  = node;
      i_wegt  = wegt;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic consume();
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
   endtask

   logic [127:0] held;

   initial begin
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      i_run    = 1'b0;
      i_len    = '0;
      i_signed = 1'b0;
      i_valid  = 1'b0;
      i_node   = '0;
      i_wegt   = '0;
      i_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready",  o_ready,  0);
      chk("rst_valid",  o_valid,  0);
      chk("rst_busy",   o_busy,   0);
      chk("rst_result", o_result, 0);
      chk("rst_sat",    o_sat,    0);
      reset_n = 1'b1;

      // unsigned len=3
      start(3, 1'b0);
      chk("u3_ready_after_run", o_ready, 1);
      chk("u3_busy", o_busy, 1);
      beat(8'd1, {8'd0, 8'd0, 8'd1, 8'd4});
      beat(8'd2, {8'd0, 8'd0, 8'd1, 8'd5});
      beat(8'd3, {8'd0, 8'd0, 8'd1, 8'd6});
      chk("u3_ready_low_after_last", o_ready, 0);
      chk("u3_valid_not_early", o_valid, 0);
      @(negedge clk);
      chk("u3_valid", o_valid, 1);
      chk("u3_result", o_result, {32'd0, 32'd0, 32'd6, 32'd32});
      chk("u3_sat", o_sat, 0);

      // back-pressure in DONE with input offered
      held = o_result;
      for (int c = 0; c < 5; c++) begin
         i_valid = 1'b1;
         i_node  = 8'd9;
         i_wegt  = 32'h0909_0909;
         @(negedge clk);
         chk("hold_valid", o_valid, 1);
         chk("hold_ready", o_ready, 0);
         chk("hold_result", o_result, {32'd0, 32'd0, 32'd6, 32'd32});
      end
      i_valid = 1'b0;
      consume();
      chk("consume_valid_low", o_valid, 0);
      chk("consume_idle", o_busy, 0);
      chk("consume_result_kept", o_result, held);

      // signed len=1: -1 * 127
      start(1, 1'b1);
      beat(8'hFF, {24'd0, 8'h7F});
      @(negedge clk);
      chk("s1_valid", o_valid, 1);
      chk("s1_result", o_result, {32'd0, 32'd0, 32'd0, 32'hFFFF_FF81});
      consume();

      // unsigned, same data: 255 * 127
      start(1, 1'b0);
      beat(8'hFF, {24'd0, 8'h7F});
      @(negedge clk);
      chk("u1_valid", o_valid, 1);
      chk("u1_result", o_result, {32'd0, 32'd0, 32'd0, 32'h0000_7E81});
      consume();

      // abort after 2 of 4 beats, restart with len=2
      start(4, 1'b0);
      beat(8'd1, 32'h0101_0101);
      beat(8'd1, 32'h0101_0101);
      start(2, 1'b0);
      chk("abort_cleared", o_result, 0);
      chk("abort_ready", o_ready, 1);
      beat(8'd3, 32'h0101_0101);
      beat(8'd4, 32'h0101_0101);
      @(negedge clk);
      chk("abort_valid", o_valid, 1);
      chk("abort_result", o_result, {32'd7, 32'd7, 32'd7, 32'd7});
      consume();

      // zero-length run is ignored
      start(0, 1'b0);
      chk("len0_busy", o_busy, 0);
      chk("len0_ready", o_ready, 0);
      chk("len0_result_kept", o_result, {32'd7, 32'd7, 32'd7, 32'd7});

      // reset mid-run
      start(3, 1'b0);
      beat(8'd5, 32'h0202_0202);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mrst_ready",  o_ready,  0);
      chk("mrst_valid",  o_valid,  0);
      chk("mrst_busy",   o_busy,   0);
      chk("mrst_result", o_result, 0);
      reset_n = 1'b1;
      start(1, 1'b0);
      beat(8'd2, {8'd4, 8'd3, 8'd2, 8'd1});
      @(negedge clk);
      chk("post_rst_valid", o_valid, 1);
      chk("post_rst_result", o_result, {32'd8, 32'd6, 32'd4, 32'd2});
      consume();

      // overflow of a 16-bit accumulator
      start(2, 1'b0);
      beat(8'd255, 32'hFFFF_FFFF);
      beat(8'd255, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("ovf_valid16", o_valid16, 1);
      chk("ovf_wide_result", o_result, {4{32'h0001_FC02}});
      chk("ovf_wide_sat", o_sat, 0);
`ifdef FC_MAC_SAT_EN
      chk("ovf16_result", o_result16, {4{16'hFFFF}});
      chk("ovf16_sat", o_sat16, 4'hF);
`else
      chk("ovf16_result", o_result16, {4{16'hFC02}});
      chk("ovf16_sat", o_sat16, 4'h0);
`endif
      consume();
      chk("ovf16_idle", o_busy16, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
